// File: rtl/data_sram_responder_pkg.sv
// Shared types and constants for the data SRAM responder: FSM state encoding,
// delay-counter width and the EX/MEM request bundle width.
package data_sram_responder_pkg;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_WAIT = 2'd1,
    RSP_RESP = 2'd2
  } rsp_state_e;

  // Wide enough for LATENCY-1 (max 14) plus up to 3 random extra cycles.
  localparam int unsigned RSP_CNT_W = 5;

  // req + wr + wstrb + addr + wdata, as carried by the EX/MEM request bundle.
  localparam int unsigned RSP_REQ_W = 1 + 1 + 4 + 32 + 32;

endpackage : data_sram_responder_pkg

// File: rtl/sram_bank_byte_we.sv
// Word-organised SRAM bank: 2**DEPTH_LOG2 words x 32 bits, synchronous
// read-first port with four byte-lane write enables.
module sram_bank_byte_we #(
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic [3:0]            we_i,
  input  logic [DEPTH_LOG2-1:0] idx_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**DEPTH_LOG2];
  logic [31:0] rdata_q;

  // NOTE: the array and its read register carry no reset so the tools can map
  // them onto block RAM; only the responder's control state is reset.
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (we_i[lane]) mem_q[idx_i][8*lane +: 8] <= wdata_i[8*lane +: 8];
      end
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : sram_bank_byte_we

// File: rtl/data_sram_responder.sv
// Responder end of the CPU data-memory interface (addr_ok/data_ok handshake).
// Define RANDOM_DELAY_EN to add 0..3 LFSR-driven extra wait cycles per request.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  rsp_state_e           state_q, state_d;
  logic [RSP_CNT_W-1:0] cnt_q, cnt_d;
  logic [RSP_CNT_W-1:0] extra;
  logic [RSP_CNT_W-1:0] total_wait;
  logic                 wr_q;
  logic                 accept;
  logic [31:0]          bank_rdata;
  logic                 unused_addr_bits;

  assign accept           = req && (state_q == RSP_IDLE);
  assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

`ifdef RANDOM_DELAY_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, free-running from the reset seed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_q <= 8'h5A;
    else         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign extra = {{(RSP_CNT_W-2){1'b0}}, lfsr_q[1:0]};
`else
  assign extra = '0;
`endif

  // Number of WAIT cycles between accept and the RESP cycle.
  assign total_wait = RSP_CNT_W'(LATENCY - 1) + extra;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RSP_IDLE: begin
        if (accept) begin
          cnt_d   = total_wait - 1'b1;
          state_d = (total_wait == '0) ? RSP_RESP : RSP_WAIT;
        end
      end
      RSP_WAIT: begin
        if (cnt_q == '0) state_d = RSP_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RSP_RESP: state_d = RSP_IDLE;
      default:  state_d = RSP_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RSP_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) wr_q <= wr;
    end
  end

  sram_bank_byte_we #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_bank (
    .clk    (clk),
    .en_i   (accept),
    .we_i   (wr ? wstrb : 4'b0000),
    .idx_i  (addr[DEPTH_LOG2+1:2]),
    .wdata_i(wdata),
    .rdata_o(bank_rdata)
  );

  // The bank's read register holds the word from accept onward; it is exposed
  // only in the RESP cycle of a load, so rdata reads 0 at all other times.
  assign addr_ok = (state_q == RSP_IDLE);
  assign data_ok = (state_q == RSP_RESP);
  assign rdata   = (data_ok && !wr_q) ? bank_rdata : 32'h0;

endmodule : data_sram_responder

// File: tb/tb_data_sram_responder.sv
// Self-checking bench: a LATENCY=1 and a LATENCY=4 responder driven by
// directed vectors, reset sequences and a scoreboarded random phase.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req, wr, sel;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;

  logic        req_a, addr_ok_a, data_ok_a;
  logic        req_b, addr_ok_b, data_ok_b;
  logic [31:0] rdata_a, rdata_b;
  logic        addr_ok_m, data_ok_m;
  logic [31:0] rdata_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign req_a     = req && !sel;
  assign req_b     = req && sel;
  assign addr_ok_m = sel ? addr_ok_b : addr_ok_a;
  assign data_ok_m = sel ? data_ok_b : data_ok_a;
  assign rdata_m   = sel ? rdata_b : rdata_a;

  data_sram_responder #(.DEPTH_LOG2(12), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .resetn(resetn), .req(req_a), .wr(wr), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok_a), .data_ok(data_ok_a),
    .rdata(rdata_a)
  );

  data_sram_responder #(.DEPTH_LOG2(12), .LATENCY(4)) u_dut_l4 (
    .clk(clk), .resetn(resetn), .req(req_b), .wr(wr), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok_b), .data_ok(data_ok_b),
    .rdata(rdata_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request (req held until data_ok) on the selected DUT; returns the
  // rdata seen with data_ok and the accept-to-data_ok latency in cycles.
  task automatic run_txn(input logic s, input logic w, input logic [3:0] strb,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output int lat);
    int n;
    sel = s; wr = w; wstrb = strb; addr = a; wdata = d; req = 1'b1;
    rd = 32'h0; lat = 0;
    #1;
    n = 0;
    while (!addr_ok_m && n < 50) begin @(negedge clk); n++; end
    if (!addr_ok_m) begin
      check("accept_timeout", {31'b0, addr_ok_m}, 32'd1);
      req = 1'b0;
      return;
    end
    @(negedge clk);
    lat = 1;
    while (!data_ok_m && lat < 40) begin
      check("busy_addr_ok", {31'b0, addr_ok_m}, 32'd0);
      @(negedge clk);
      lat++;
    end
    if (!data_ok_m) begin
      check("data_ok_timeout", {31'b0, data_ok_m}, 32'd1);
      req = 1'b0;
      return;
    end
    rd = rdata_m;
    check("resp_addr_ok", {31'b0, addr_ok_m}, 32'd0);
    req = 1'b0;
    @(negedge clk);
    check("data_ok_pulse", {31'b0, data_ok_m}, 32'd0);
    check("rdata_clear",   rdata_m, 32'h0);
    check("idle_addr_ok",  {31'b0, addr_ok_m}, 32'd1);
  endtask

  typedef struct {
    string       name;
    logic        sel;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs [10];
  logic [31:0] model [16];
  logic [31:0] rd;
  int          lat, exp_lat;
  logic [3:0]  extras_seen;

  initial begin
    vecs[0] = '{"st_full",     1'b0, 1'b1, 4'b1111, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{"ld_full",     1'b0, 1'b0, 4'b1111, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{"st_lane2",    1'b0, 1'b1, 4'b0100, 32'h0000_0102, 32'h00AB_0000, 32'h0};
    vecs[3] = '{"ld_lane2",    1'b0, 1'b0, 4'b0000, 32'h0000_0100, 32'h0,         32'hDEAB_BEEF};
    vecs[4] = '{"st_nostrb",   1'b0, 1'b1, 4'b0000, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0};
    vecs[5] = '{"ld_nostrb",   1'b0, 1'b0, 4'b0000, 32'h0000_0100, 32'h0,         32'hDEAB_BEEF};
    vecs[6] = '{"st_lane03",   1'b0, 1'b1, 4'b1001, 32'h0000_0100, 32'h55AA_AA66, 32'h0};
    vecs[7] = '{"ld_alias_l1", 1'b0, 1'b0, 4'b0000, 32'hFFFF_C102, 32'h0,         32'h55AB_BE66};
    vecs[8] = '{"st_wrap_l4",  1'b1, 1'b1, 4'b1111, 32'h4000_0100, 32'h1234_5678, 32'h0};
    vecs[9] = '{"ld_wrap_l4",  1'b1, 1'b0, 4'b0000, 32'h0000_0100, 32'h0,         32'h1234_5678};

    resetn = 1'b0; req = 1'b1; wr = 1'b0; sel = 1'b0;
    wstrb = 4'b1111; addr = 32'h0; wdata = 32'h0;

    // Reset held for 3 cycles with req asserted: both DUTs stay idle.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        sel = s[0]; #1;
        check("rst_addr_ok", {31'b0, addr_ok_m}, 32'd1);
        check("rst_data_ok", {31'b0, data_ok_m}, 32'd0);
        check("rst_rdata",   rdata_m, 32'h0);
      end
    end
    req = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      exp_lat = vecs[i].sel ? 4 : 1;
      run_txn(vecs[i].sel, vecs[i].wr, vecs[i].strb, vecs[i].addr, vecs[i].wdata, rd, lat);
      check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
`ifdef RANDOM_DELAY_EN
      check({vecs[i].name, "_lat"}, {31'b0, (lat >= exp_lat) && (lat <= exp_lat + 3)}, 32'd1);
`else
      check({vecs[i].name, "_lat"}, lat, exp_lat);
`endif
    end

    // Store accepted on the LATENCY=4 DUT, reset pulsed during WAIT.
    sel = 1'b1; wr = 1'b1; wstrb = 4'b1111; addr = 32'h300; wdata = 32'hAABB_CCDD; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("mid_wait_addr_ok", {31'b0, addr_ok_m}, 32'd0);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_addr_ok", {31'b0, addr_ok_m}, 32'd1);
    for (int c = 0; c < 8; c++) begin
      check("post_rst_no_data_ok", {31'b0, data_ok_m}, 32'd0);
      @(negedge clk);
    end
    run_txn(1'b1, 1'b0, 4'b0000, 32'h300, 32'h0, rd, lat);
    check("rst_kept_store", rd, 32'hAABB_CCDD);

    // Load accepted, reset pulsed during WAIT: no completion may follow.
    sel = 1'b1; wr = 1'b0; addr = 32'h300; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("ld_rst_addr_ok", {31'b0, addr_ok_m}, 32'd1);
    for (int c = 0; c < 8; c++) begin
      check("ld_rst_no_data_ok", {31'b0, data_ok_m}, 32'd0);
      check("ld_rst_rdata", rdata_m, 32'h0);
      @(negedge clk);
    end

    // Scoreboarded random phase on the LATENCY=4 DUT, words 0x80..0x8F.
    extras_seen = 4'b0;
    for (int w = 0; w < 16; w++) begin
      model[w] = $urandom;
      run_txn(1'b1, 1'b1, 4'b1111, 32'h200 | (w << 2), model[w], rd, lat);
    end
    for (int t = 0; t < 200; t++) begin
      int          w;
      logic        is_wr;
      logic [3:0]  strb;
      logic [31:0] a, d, exp_rd;
      w     = $urandom_range(0, 15);
      is_wr = $urandom_range(0, 1) == 1;
      strb  = 4'($urandom);
      d     = $urandom;
      a     = ($urandom & 32'hFFFF_C000) | 32'h200 | (w << 2) | $urandom_range(0, 3);
      exp_rd = is_wr ? 32'h0 : model[w];
      if (is_wr) begin
        for (int l = 0; l < 4; l++) if (strb[l]) model[w][8*l +: 8] = d[8*l +: 8];
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn(1'b1, is_wr, strb, a, d, rd, lat);
      check("rand_rdata", rd, exp_rd);
`ifdef RANDOM_DELAY_EN
      check("rand_lat", {31'b0, (lat >= 4) && (lat <= 7)}, 32'd1);
      if (lat >= 4 && lat <= 7) extras_seen[lat - 4] = 1'b1;
`else
      check("rand_lat", lat, 4);
`endif
    end
`ifdef RANDOM_DELAY_EN
    check("extras_all_seen", {28'b0, extras_seen}, 32'hF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_data_sram_responder

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Responder (slave) end of the CPU data-memory interface: accepts load/store requests from the EX/MEM pipeline and returns read data that the MEM stage aligns and extends.
- Request/response handshake: addr_ok accepts a request, data_ok returns completion.
- Word-organised memory with byte-lane write strobes.
- Used as the bench-side and FPGA-side data SRAM for the pipelined CPU.

Parameters:
- DEPTH_LOG2, 12, log2 of memory depth in 32-bit words (default 4096 words = 16 KiB).
- LATENCY, 1, cycles from accept to data_ok; legal range 1..15.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- resetn  input  1  asynchronous active-low reset.
- req  input  1  request valid.
- wr  input  1  1 = store, 0 = load; sampled with req.
- wstrb  input  4  byte-lane write enables; bit i writes wdata[8i+7:8i]; ignored when wr=0.
- addr  input  32  byte address; bits [1:0] ignored, bits [DEPTH_LOG2+1:2] index the word.
- wdata  input  32  store data, already lane-aligned by the requester.
- addr_ok  output  1  request accepted this cycle when req & addr_ok.
- data_ok  output  1  one-cycle completion pulse.
- rdata  output  32  full aligned word; valid only while data_ok=1.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE; data_ok=0; rdata=0; delay counter=0; any pending response is discarded.
  - Memory array is not reset.
- FSM states IDLE, WAIT, RESP:
  - IDLE: addr_ok=1. On req=1, latch wr, the word index and the read word; go to WAIT if LATENCY>1, else go to RESP.
  - WAIT: addr_ok=0. Counter is loaded with LATENCY-2 at accept and decrements; at 0, go to RESP.
  - RESP: addr_ok=0, data_ok=1 for exactly this cycle. Next state is IDLE.
- addr_ok is a pure decode of state (state==IDLE); it has no combinational path from req.
- Single outstanding request. Back-to-back throughput is one request per LATENCY+1 cycles.
- Store: memory bytes are written at the accepting edge per wstrb; wstrb=0000 writes nothing. data_ok still pulses, with rdata=0.
- Load: the word is read at the accepting edge. rdata is registered and held stable through the data_ok cycle; it returns to 0 after.
- Ordering: a load accepted after a store sees the stored bytes, because the write is applied at accept. No bypass is required since only one request is outstanding.
- Address wrap: upper address bits above DEPTH_LOG2+1 are ignored (aliasing). Bits [1:0] are ignored; the MEM stage performs the byte/half shift and sign extension.
- req while not in IDLE is ignored; the requester must hold req until addr_ok.
- Reset asserted mid-transaction: no data_ok is produced. A store already accepted stays written; a store not yet accepted is not written.

Optional Feature:
- Macro: RANDOM_DELAY_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'h5A; advances every cycle) supplies 0..3 extra WAIT cycles. The value is lfsr[1:0], sampled at accept.
  - The extra cycles are added to LATENCY; WAIT is entered even when LATENCY=1 if the extra count is nonzero.
  - Purpose: stress pipeline stall logic.
- Undefined: latency is exactly LATENCY, and no LFSR logic is present.

Decomposition:
- Shared header mycpu_head.h gets:
  - state encodings RSP_IDLE=2'd0, RSP_WAIT=2'd1, RSP_RESP=2'd2;
  - the request field width macro used by the EX/MEM request bundle.
- One sub-module, sram_bank_byte_we: DEPTH words x 32, synchronous read, 4 byte write enables.
- FSM, counter and LFSR stay in the top module.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with req=1 → addr_ok=1, data_ok=0, rdata=0 throughout.
- Full-word store/load round trip (LATENCY=1):
  - Store addr=0x100, wdata=0xDEADBEEF, wstrb=1111. Then load addr=0x100.
  - → store data_ok 1 cycle after accept with rdata=0; load data_ok 1 cycle after accept with rdata=0xDEADBEEF.
  - addr_ok=0 during each outstanding cycle.
- Partial-lane store:
  - Store addr=0x102, wdata=0x00AB0000, wstrb=0100, then load addr=0x100.
  - → rdata=0xDEABBEEF.
- Wrap and latency (LATENCY=4, DEPTH_LOG2=12):
  - Store 0x12345678 to addr=0x4000_0100; load addr=0x100.
  - → rdata=0x12345678; data_ok exactly 4 cycles after each accept.
  - req held during WAIT is not re-accepted.
- Reset mid-operation (LATENCY=4):
  - Accept a load, drop resetn for 1 cycle during WAIT.
  - → no data_ok ever; IDLE and addr_ok=1 on the first cycle after release.
- RANDOM_DELAY_EN:
  - 200 random loads/stores checked against a scoreboard.
  - → every data_ok latency falls in LATENCY..LATENCY+3, and all four extra-delay values occur.
  - No data mismatch.
